// File: rtl/demux_sched_pkg.sv
// Shared types, constants and the round-robin helper for demux_burst_sched.
package demux_sched_pkg;
  localparam int unsigned NUM_DEST = 4;
  localparam int unsigned SEL_W    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PICK = 2'd1,
    XFER = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } rr_result_t;

  // First set mask bit strictly after last, wrapping; found=0 when mask is empty.
  function automatic rr_result_t next_rr(input logic [SEL_W-1:0]    last,
                                         input logic [NUM_DEST-1:0] mask);
    rr_result_t       res;
    logic [SEL_W-1:0] cand;
    res = '0;
    for (int unsigned k = 1; k <= NUM_DEST; k++) begin
      cand = last + SEL_W'(k);
      if (!res.found && mask[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction
endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin selector used by demux_burst_sched.
module rr_pick4
  import demux_sched_pkg::*;
(
  input  logic [SEL_W-1:0]    last,
  input  logic [NUM_DEST-1:0] mask,
  output logic [SEL_W-1:0]    idx_c,
  output logic                found_c
);
  rr_result_t res;

  always_comb begin
    res     = next_rr(last, mask);
    idx_c   = res.idx;
    found_c = res.found;
  end
endmodule

// File: rtl/demux_burst_sched.sv
// Round-robin burst scheduler feeding a 1:4 demux through a one-entry output register.
// Optional per-destination delivery counters when DEMUX_SCHED_STATS_EN is defined.
module demux_burst_sched
  import demux_sched_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [NUM_DEST-1:0]       mask,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_ready,
  output logic [NUM_DEST-1:0]       out_valid,
  output logic [DATA_W-1:0]         out_data,
  input  logic [NUM_DEST-1:0]       out_ready,
  output logic [SEL_W-1:0]          sel,
  output logic                      busy
`ifdef DEMUX_SCHED_STATS_EN
  ,
  output logic [NUM_DEST*CNT_W-1:0] beat_cnt
`endif
);
  localparam int unsigned BC_W = $clog2(BURST_LEN + 1);

  sched_state_e      state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  last_q, last_d;
  logic [BC_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              buf_v_q, buf_v_d;

  logic [SEL_W-1:0]  pick_idx;
  logic              pick_found;
  logic              accept;
  logic              deliver;

  rr_pick4 u_pick (
    .last    (last_q),
    .mask    (mask),
    .idx_c   (pick_idx),
    .found_c (pick_found)
  );

  // Next-state, buffer and handshake logic.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    buf_d       = buf_q;
    buf_v_d     = buf_v_q;
    in_ready    = 1'b0;
    accept      = 1'b0;
    deliver     = buf_v_q && out_ready[sel_q];

    unique case (state_q)
      IDLE: begin
        if (enable && |mask) state_d = PICK;
      end
      PICK: begin
        if (pick_found) begin
          sel_d       = pick_idx;
          last_d      = pick_idx;
          burst_cnt_d = '0;
          state_d     = XFER;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        in_ready = (burst_cnt_q < BC_W'(BURST_LEN)) && (!buf_v_q || out_ready[sel_q]);
        accept   = in_valid && in_ready;
        if (accept) begin
          buf_d       = in_data;
          buf_v_d     = 1'b1;
          burst_cnt_d = burst_cnt_q + BC_W'(1);
        end else if (deliver) begin
          buf_v_d = 1'b0;
        end
        // Burst ends only once every beat has left the output register.
        if ((burst_cnt_q == BC_W'(BURST_LEN)) && (!buf_v_q || deliver)) begin
          state_d = (enable && |mask) ? PICK : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      last_q      <= SEL_W'(NUM_DEST - 1);
      burst_cnt_q <= '0;
      buf_q       <= '0;
      buf_v_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      buf_q       <= buf_d;
      buf_v_q     <= buf_v_d;
    end
  end

  assign out_valid = buf_v_q ? (NUM_DEST'(1) << sel_q) : '0;
  assign out_data  = buf_q;
  assign sel       = sel_q;
  assign busy      = (state_q != IDLE);

`ifdef DEMUX_SCHED_STATS_EN
  logic [NUM_DEST*CNT_W-1:0] cnt_q, cnt_d;

  // Per-destination delivered-beat counters, wrapping.
  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < NUM_DEST; i++) begin
      if (deliver && (sel_q == SEL_W'(i))) begin
        cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign beat_cnt = cnt_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^32'(CNT_W);
`endif
endmodule
